// File: rtl/tqvp_segment_reader.sv
// tqvp_segment_reader
//   TinyQV peripheral that watches an externally driven 7-segment pattern,
//   synchronises and debounces it, decodes it back to a hex/BCD digit and
//   queues each newly accepted digit in a small FIFO for the CPU to pop.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-high
//   ui_in      [6:0] segments a..g, [7] unused
//   uo_out     {fifo_nonempty, 2'b00, last_invalid, last_code[3:0]} when ECHO, else 0
//   address    register address
//   data_write write strobe, data_in valid
//   data_in    write data
//   data_out   read data, combinational from address
//
// Register map
//   @0 DATA  R: {nonempty, 0, head[5:0]}            W: pop one entry
//   @1 CTRL  R/W: [7]EN [6]AL [5]HEX [4]PB [3]ECHO  W: [0]CLR flushes FIFO and OVF
//   @2 STAT  R: {full, empty, OVF, 0, count[3:0]}   W: [5]=1 clears OVF
//   @3 RAW   R: {0, seg}
//   @4 LAST  R: {accepted_valid, 0, decode(accepted)}
//   others read 8'hFF
module tqvp_segment_reader #(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    localparam int unsigned CntW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);
    localparam logic [CntW-1:0] CntPre = CntW'(STABLE_CYCLES - 2);
    localparam logic [3:0] CountFull = 4'(FIFO_DEPTH);

    // Entry / decode result: {blank, invalid, code[3:0]}
    function automatic logic [5:0] decode(input logic [6:0] s, input logic hex);
        logic [5:0] r;
        r = 6'h10;
        case (s)
            7'h00: r = 6'h20;
            7'h3F: r = 6'h00;
            7'h06: r = 6'h01;
            7'h5B: r = 6'h02;
            7'h4F: r = 6'h03;
            7'h66: r = 6'h04;
            7'h6D: r = 6'h05;
            7'h7D: r = 6'h06;
            7'h07, 7'h27: r = 6'h07;
            7'h7F: r = 6'h08;
            7'h6F, 7'h67: r = 6'h09;
            7'h77: if (hex) r = 6'h0A;
            // Tail-less 6 and lowercase b share a pattern; HEX picks the reading.
            7'h7C: r = hex ? 6'h0B : 6'h06;
            7'h39, 7'h58: if (hex) r = 6'h0C;
            7'h5E: if (hex) r = 6'h0D;
            7'h79: if (hex) r = 6'h0E;
            7'h71: if (hex) r = 6'h0F;
            default: r = 6'h10;
        endcase
        return r;
    endfunction

    // Control
    logic en_q, al_q, hex_q, pb_q, echo_q;

    // Input path and filter
    logic [6:0]      sync1_q, sync2_q, seg;
    logic [6:0]      cand_q, cand_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [6:0]      acc_q, acc_d;
    logic            acc_valid_q, acc_valid_d;
    logic            push_q, push_d;

    // FIFO
    logic [5:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [3:0]      count_q, count_d;
    logic            ovf_q, ovf_d;

    logic       ctrl_wr, clr, pop, ovf_clr, push_ok, wr_en, full, empty;
    logic [5:0] dec_acc, head;
    logic       unused_bits;

    assign unused_bits = ^{ui_in[7], data_in[2:1]};

    assign seg     = al_q ? ~sync2_q : sync2_q;
    assign dec_acc = decode(acc_q, hex_q);

    assign full    = (count_q == CountFull);
    assign empty   = (count_q == 4'd0);
    assign head    = empty ? 6'h00 : mem_q[rd_q];

    assign ctrl_wr = data_write && (address == 4'd1);
    assign clr     = ctrl_wr && data_in[0];
    assign pop     = data_write && (address == 4'd0) && !empty;
    assign ovf_clr = data_write && (address == 4'd2) && data_in[5];
    // A blank acceptance still updates LAST but only enters the FIFO with PB set.
    assign push_ok = push_q && !((acc_q == 7'h00) && !pb_q);
    // A pop frees the slot in the same cycle, so a full FIFO can still accept.
    assign wr_en   = push_ok && (!full || pop) && !clr;

    always_comb begin
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        acc_valid_d = acc_valid_q;
        push_d      = 1'b0;
        if (!en_q) begin
            cand_d      = '0;
            cnt_d       = '0;
            acc_valid_d = 1'b0;
        end else if (seg != cand_q) begin
            cand_d = seg;
            cnt_d  = '0;
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 1'b1;
            // Only the step onto CntMax can accept; saturation keeps it one-shot.
            if ((cnt_q == CntPre) && (!acc_valid_q || (cand_q != acc_q))) begin
                acc_d       = cand_q;
                acc_valid_d = 1'b1;
                push_d      = 1'b1;
            end
        end
    end

    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clr) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            if (pop) rd_d = rd_q + 1'b1;
            if (wr_en) wr_d = wr_q + 1'b1;
            case ({wr_en, pop})
                2'b10:   count_d = count_q + 4'd1;
                2'b01:   count_d = count_q - 4'd1;
                default: count_d = count_q;
            endcase
            if (ovf_clr) ovf_d = 1'b0;
            // Overflow is applied after the clear so a same-cycle drop wins.
            if (push_ok && full && !pop) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            en_q        <= 1'b0;
            al_q        <= 1'b1;
            hex_q       <= 1'b1;
            pb_q        <= 1'b0;
            echo_q      <= 1'b0;
            cand_q      <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            acc_valid_q <= 1'b0;
            push_q      <= 1'b0;
            rd_q        <= '0;
            wr_q        <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            sync1_q     <= ui_in[6:0];
            sync2_q     <= sync1_q;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            acc_valid_q <= acc_valid_d;
            push_q      <= push_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            if (ctrl_wr) begin
                {en_q, al_q, hex_q, pb_q, echo_q} <= data_in[7:3];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_q] <= decode(acc_q, hex_q);
        end
    end

    always_comb begin
        case (address)
            4'd0:    data_out = {!empty, 1'b0, head};
            4'd1:    data_out = {en_q, al_q, hex_q, pb_q, echo_q, 3'b000};
            4'd2:    data_out = {full, empty, ovf_q, 1'b0, count_q};
            4'd3:    data_out = {1'b0, seg};
            4'd4:    data_out = {acc_valid_q, 1'b0, dec_acc};
            default: data_out = 8'hFF;
        endcase
    end

    assign uo_out = echo_q ? {!empty, 2'b00, dec_acc[4:0]} : 8'h00;

endmodule
